// File: rtl/bus_debug_pkg.sv
// Shared definitions for the byte-stream bus debug initiator: FSM states,
// status codes returned to the host, and the layout of the opcode byte.
package bus_debug_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        REQ,
        RESP,
        STATUS,
        RDATA
    } state_t;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BUSERR  = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;
    localparam logic [7:0] ST_BADOP   = 8'hE1;

    localparam int OP_WE_BIT  = 7;
    localparam int OP_RSV_MSB = 6;
    localparam int OP_RSV_LSB = 4;
    localparam int OP_BE_MSB  = 3;
    localparam int OP_BE_LSB  = 0;

    // An opcode is usable only with the reserved field clear and at least one byte lane enabled.
    function automatic logic op_is_legal(input logic [7:0] op);
        return (op[OP_RSV_MSB:OP_RSV_LSB] == 3'b000) && (op[OP_BE_MSB:OP_BE_LSB] != 4'b0000);
    endfunction

endpackage

// File: rtl/bus_debug_master.sv
// Host-driven data-bus initiator: parses opcode/address/write-data bytes,
// issues one req/gnt/rvalid transaction, and streams back a status byte
// followed by the read word (LSB first) on a successful read.
module bus_debug_master
    import bus_debug_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    localparam int TMO_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_W   = (TMO_RAW < 1) ? 1 : TMO_RAW;
    // Abort fires at the end of the TIMEOUT_CYCLES-th cycle spent waiting.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [1:0]         byte_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               wr_en;
    logic [3:0]         byte_en;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic [7:0]         status_d;
    logic [1:0]         rd_idx;
    logic [7:0]         rdata_byte;
    logic               cmd_hs;
    logic               rsp_hs;
    logic               op_legal;
    logic               tmo_hit;

    assign cmd_ready = (state == IDLE) || (state == ADDR) || (state == WDATA);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign op_legal  = op_is_legal(cmd_data);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    assign data_req_o   = (state == REQ);
    assign data_we_o    = wr_en;
    assign data_be_o    = byte_en;
    assign data_addr_o  = addr;
    assign data_wdata_o = wdata;

    // Byte 0 goes out on entry to RDATA; later bytes follow each handshake.
    assign rd_idx     = (state == RDATA) ? byte_cnt + 2'd1 : 2'd0;
    assign rdata_byte = rdata[{rd_idx, 3'b000} +: 8];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and the status code to report on entry to STATUS.
    always_comb begin
        state_next = state;
        status_d   = ST_OK;
        unique case (state)
            IDLE: begin
                if (cmd_hs) begin
                    if (op_legal) begin
                        state_next = ADDR;
                    end else begin
                        state_next = STATUS;
                        status_d   = ST_BADOP;
                    end
                end
            end
            ADDR: begin
                if (cmd_hs && byte_cnt == 2'd3) begin
                    state_next = wr_en ? WDATA : REQ;
                end
            end
            WDATA: begin
                if (cmd_hs && byte_cnt == 2'd3) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_next = RESP;
                end else if (tmo_hit) begin
                    state_next = STATUS;
                    status_d   = ST_TIMEOUT;
                end
            end
            RESP: begin
                if (data_rvalid_i) begin
                    state_next = STATUS;
                    status_d   = data_err_i ? ST_BUSERR : ST_OK;
                end else if (tmo_hit) begin
                    state_next = STATUS;
                    status_d   = ST_TIMEOUT;
                end
            end
            STATUS: begin
                if (rsp_hs) begin
                    state_next = (!wr_en && rsp_data == ST_OK) ? RDATA : IDLE;
                end
            end
            RDATA: begin
                if (rsp_hs && byte_cnt == 2'd3) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-state byte counter and wait-cycle counter, both restarted on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            tmo_cnt  <= '0;
        end else if (state_next != state) begin
            byte_cnt <= 2'd0;
            tmo_cnt  <= '0;
        end else begin
            if (cmd_hs || (state == RDATA && rsp_hs)) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == REQ || state == RESP) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    // Capture frame fields from the command stream and read data from the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            byte_en <= 4'b0000;
            addr    <= 32'h0;
            wdata   <= 32'h0;
            rdata   <= 32'h0;
        end else begin
            if (state == IDLE && cmd_hs && op_legal) begin
                wr_en   <= cmd_data[OP_WE_BIT];
                byte_en <= cmd_data[OP_BE_MSB:OP_BE_LSB];
            end
            if (state == ADDR && cmd_hs) begin
                // Word addressing: the two lowest address bits are never stored.
                addr[{byte_cnt, 3'b000} +: 8] <= (byte_cnt == 2'd0) ? (cmd_data & 8'hFC) : cmd_data;
            end
            if (state == WDATA && cmd_hs) begin
                wdata[{byte_cnt, 3'b000} +: 8] <= cmd_data;
            end
            if (state == RESP && data_rvalid_i && !data_err_i && !wr_en) begin
                rdata <= data_rdata_i;
            end
        end
    end

    // Registered response byte: loaded on entry to STATUS/RDATA and after each RDATA handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            rsp_valid <= (state_next == STATUS) || (state_next == RDATA);
            if (state_next == STATUS && state != STATUS) begin
                rsp_data <= status_d;
            end else if (state_next == RDATA && (state != RDATA || rsp_hs)) begin
                rsp_data <= rdata_byte;
            end
        end
    end

endmodule

// File: tb/tb_bus_debug_master.sv
// Bench for bus_debug_master: directed frame table, randomized frames scored
// against a frame-level reference model, and a reset-during-response sequence.
module tb_bus_debug_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    always #5 clk = ~clk;

    bus_debug_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .data_req_o   (data_req_o),
        .data_gnt_i   (data_gnt_i),
        .data_rvalid_i(data_rvalid_i),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_addr_o  (data_addr_o),
        .data_wdata_o (data_wdata_o),
        .data_rdata_i (data_rdata_i),
        .data_err_i   (data_err_i)
    );

    // Command bytes and response bytes are packed with element [0] in the low byte,
    // so literals read right-to-left in transmission order.
    typedef struct {
        int              n;
        logic [8:0][7:0] cmd;
        int              gnt_dly;
        int              rv_dly;
        logic            err;
        logic [31:0]     rdata;
        int              stall;
        logic            stray;
        int              exp_n;
        logic [4:0][7:0] exp;
        logic            exp_req;
        logic [31:0]     exp_addr;
        logic            exp_we;
        logic [3:0]      exp_be;
        logic [31:0]     exp_wdata;
        int              exp_req_cycles;
    } vec_t;

    int total_cnt = 0;
    int pass_cnt  = 0;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t stim(input int n, input logic [71:0] cmd, input int gnt_dly, input int rv_dly,
                                  input logic err, input logic [31:0] rdata, input int stall, input logic stray);
        vec_t v;
        v.n = n; v.cmd = cmd; v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.err = err;
        v.rdata = rdata; v.stall = stall; v.stray = stray;
        v.exp_n = 0; v.exp = '0; v.exp_req = 1'b0; v.exp_addr = '0; v.exp_we = 1'b0;
        v.exp_be = '0; v.exp_wdata = '0; v.exp_req_cycles = -1;
        return v;
    endfunction

    function automatic vec_t with_exp(input vec_t v, input int exp_n, input logic [39:0] exp, input logic req,
                                      input logic [31:0] addr, input logic we, input logic [3:0] be,
                                      input logic [31:0] wdata, input int req_cycles);
        vec_t m;
        m = v;
        m.exp_n = exp_n; m.exp = exp; m.exp_req = req; m.exp_addr = addr; m.exp_we = we;
        m.exp_be = be; m.exp_wdata = wdata; m.exp_req_cycles = req_cycles;
        return m;
    endfunction

    // Frame-level reference: what the host and the bus should observe for one command frame.
    function automatic vec_t model(input vec_t v);
        vec_t m;
        logic [7:0] op;
        m = v;
        op = v.cmd[0];
        m.exp = '0;
        m.exp_req_cycles = -1;
        if (op[6:4] != 3'd0 || op[3:0] == 4'd0) begin
            m.exp_n = 1; m.exp[0] = 8'hE1; m.exp_req = 1'b0;
            return m;
        end
        m.exp_req   = 1'b1;
        m.exp_we    = op[7];
        m.exp_be    = op[3:0];
        m.exp_addr  = {v.cmd[4], v.cmd[3], v.cmd[2], v.cmd[1]} & 32'hFFFF_FFFC;
        m.exp_wdata = {v.cmd[8], v.cmd[7], v.cmd[6], v.cmd[5]};
        m.exp_n     = 1;
        if (v.gnt_dly >= TMO) begin
            m.exp_req_cycles = TMO;
            m.exp[0] = 8'h02;
        end else begin
            m.exp_req_cycles = v.gnt_dly + 1;
            if (v.rv_dly > TMO)  m.exp[0] = 8'h02;
            else if (v.err)      m.exp[0] = 8'h01;
            else if (op[7])      m.exp[0] = 8'h00;
            else begin
                m.exp_n = 5;
                m.exp[0] = 8'h00;
                for (int i = 0; i < 4; i++) m.exp[i+1] = v.rdata[8*i +: 8];
            end
        end
        return m;
    endfunction

    function automatic vec_t rand_vec();
        logic [71:0] c;
        int n;
        c[31:0]  = $urandom;
        c[63:32] = $urandom;
        c[71:64] = 8'($urandom);
        if ($urandom_range(0, 99) < 15) begin
            if ($urandom_range(0, 1) == 0) c[6:4] = 3'($urandom_range(1, 7));
            else begin c[6:4] = 3'd0; c[3:0] = 4'd0; end
            n = 1;
        end else begin
            c[6:4] = 3'd0;
            if (c[3:0] == 4'd0) c[3:0] = 4'h1;
            n = c[7] ? 9 : 5;
        end
        return stim(n, c,
                    ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 5)),
                    ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(1, 6)),
                    ($urandom_range(0, 4) == 0), $urandom, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0));
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_req"},   data_req_o, 1'b0);
        chk({tag, "_we"},    data_we_o, 1'b0);
        chk({tag, "_be"},    data_be_o, 4'h0);
        chk({tag, "_addr"},  data_addr_o, 32'h0);
        chk({tag, "_wdata"}, data_wdata_o, 32'h0);
        chk({tag, "_rspv"},  rsp_valid, 1'b0);
        chk({tag, "_rspd"},  rsp_data, 8'h00);
        chk({tag, "_cmdrdy"}, cmd_ready, 1'b1);
    endtask

    // Drives one frame cycle by cycle at the falling edge, acting as host and bus target.
    task automatic run_frame(input string tag, input vec_t v);
        logic [7:0] got[$];
        int idx = 0, req_cycles = 0, req_rises = 0, since_gnt = 0, stall_cnt = 0, post = 0, cyc = 0;
        logic granted = 0, prev_req = 0, hold = 0, pend_b2b = 0, b2b_ok = 0;
        logic stable_bad = 0, crdy_bad = 0, done = 0;
        logic [7:0]  prev_rsp = 0;
        logic [31:0] cap_addr = 0, cap_wdata = 0;
        logic        cap_we = 0;
        logic [3:0]  cap_be = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                if (hold && rsp_data !== prev_rsp) stable_bad = 1;
                if (cmd_ready) crdy_bad = 1;
            end
            if (data_req_o) begin
                req_cycles++;
                if (!prev_req) begin
                    req_rises++;
                    cap_addr = data_addr_o; cap_wdata = data_wdata_o; cap_we = data_we_o; cap_be = data_be_o;
                end else if (data_addr_o !== cap_addr || data_wdata_o !== cap_wdata ||
                             data_we_o !== cap_we || data_be_o !== cap_be) begin
                    stable_bad = 1;
                end
            end
            prev_req = data_req_o;
            if (pend_b2b) begin b2b_ok = cmd_ready; pend_b2b = 0; end
            if (idx < v.n) begin
                cmd_valid = 1; cmd_data = v.cmd[idx];
                if (cmd_ready) idx++;
            end else begin
                cmd_valid = 0;
            end
            data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = $urandom;
            if (data_req_o && req_cycles > v.gnt_dly) begin
                data_gnt_i = 1; granted = 1; since_gnt = 0;
            end else if (granted) begin
                since_gnt++;
                if (since_gnt == v.rv_dly) begin
                    data_rvalid_i = 1; data_err_i = v.err; data_rdata_i = v.rdata;
                end
            end else if (v.stray && idx < v.n && !data_req_o) begin
                data_rvalid_i = 1; data_err_i = 1;
            end
            if (rsp_valid) begin
                if (stall_cnt < v.stall) begin
                    rsp_ready = 0; stall_cnt++; hold = 1; prev_rsp = rsp_data;
                end else begin
                    rsp_ready = 1; got.push_back(rsp_data); stall_cnt = 0; hold = 0;
                    if (got.size() == v.exp_n) pend_b2b = 1;
                end
            end else begin
                rsp_ready = 0; hold = 0;
            end
            if (got.size() >= v.exp_n && idx >= v.n) post++;
            done = (post > 4) && (!granted || since_gnt > v.rv_dly);
        end
        cmd_valid = 0; rsp_ready = 0; data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0;
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_rsp_len"}, got.size(), v.exp_n);
        for (int i = 0; i < v.exp_n && i < got.size(); i++)
            chk($sformatf("%s_rsp%0d", tag, i), got[i], v.exp[i]);
        chk({tag, "_req_count"}, req_rises, v.exp_req ? 1 : 0);
        if (v.exp_req) begin
            chk({tag, "_addr"}, cap_addr, v.exp_addr);
            chk({tag, "_we"}, cap_we, v.exp_we);
            chk({tag, "_be"}, cap_be, v.exp_be);
            if (v.exp_we) chk({tag, "_wdata"}, cap_wdata, v.exp_wdata);
        end
        if (v.exp_req_cycles >= 0) chk({tag, "_req_cycles"}, req_cycles, v.exp_req_cycles);
        chk({tag, "_held_stable"}, stable_bad, 1'b0);
        chk({tag, "_cmd_ready_low"}, crdy_bad, 1'b0);
        chk({tag, "_b2b_ready"}, b2b_ok, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        cmd_valid = 1; cmd_data = b;
        while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) chk("send_byte_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic reset_in_resp();
        int guard = 0;
        logic seen = 0;
        logic [7:0] b[5] = '{8'h0F, 8'h00, 8'h00, 8'h00, 8'h70};
        for (int i = 0; i < 5; i++) send_byte(b[i]);
        while (!data_req_o && guard < 50) begin @(negedge clk); guard++; end
        chk("rir_req_seen", data_req_o, 1'b1);
        data_gnt_i = 1;
        @(negedge clk);
        data_gnt_i = 0;
        chk("rir_in_resp", {data_req_o, rsp_valid, cmd_ready}, 3'b000);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_reset("rir");
        data_rvalid_i = 1; data_rdata_i = 32'h9999_9999;
        @(negedge clk);
        data_rvalid_i = 0;
        repeat (6) begin
            if (rsp_valid) seen = 1;
            @(negedge clk);
        end
        chk("rir_no_rsp", seen, 1'b0);
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_data = 0; rsp_ready = 0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0; data_err_i = 0;

        vecs[0] = with_exp(stim(9, 72'hDEADBEEF_20000010_8F, 2, 1, 0, 32'h0, 0, 0),
                           1, 40'h00, 1, 32'h20000010, 1, 4'hF, 32'hDEADBEEF, 3);
        vecs[1] = with_exp(stim(5, 72'h20000006_03, 1, 1, 0, 32'h12345678, 0, 0),
                           5, 40'h12345678_00, 1, 32'h20000004, 0, 4'h3, 32'h0, 2);
        vecs[2] = with_exp(stim(1, 72'h30, 0, 1, 0, 32'h0, 0, 0),
                           1, 40'hE1, 0, 32'h0, 0, 4'h0, 32'h0, -1);
        vecs[3] = with_exp(stim(5, 72'h10000040_0F, 0, 2, 0, 32'hA5A50F0F, 0, 0),
                           5, 40'hA5A50F0F_00, 1, 32'h10000040, 0, 4'hF, 32'h0, 1);
        vecs[4] = with_exp(stim(5, 72'h3000000C_01, 0, 3, 1, 32'h55AA55AA, 0, 0),
                           1, 40'h01, 1, 32'h3000000C, 0, 4'h1, 32'h0, 1);
        vecs[5] = with_exp(stim(5, 72'h40000000_0F, 99, 1, 0, 32'h0, 0, 0),
                           1, 40'h02, 1, 32'h40000000, 0, 4'hF, 32'h0, 8);
        vecs[6] = with_exp(stim(5, 72'h50000008_0C, 1, 1, 0, 32'hCAFEF00D, 5, 0),
                           5, 40'hCAFEF00D_00, 1, 32'h50000008, 0, 4'hC, 32'h0, 2);
        vecs[7] = with_exp(stim(9, 72'h44332211_60000004_81, 0, 12, 0, 32'h0, 0, 0),
                           1, 40'h02, 1, 32'h60000004, 1, 4'h1, 32'h44332211, 1);
        vecs[8] = with_exp(stim(5, 72'h70000103_07, 0, 1, 0, 32'h0BADF00D, 1, 1),
                           5, 40'h0BADF00D_00, 1, 32'h70000100, 0, 4'h7, 32'h0, 1);
        vecs[9] = with_exp(stim(1, 72'h80, 0, 1, 0, 32'h0, 0, 0),
                           1, 40'hE1, 0, 32'h0, 0, 4'h0, 32'h0, -1);

        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 40; i++) run_frame($sformatf("rnd%0d", i), model(rand_vec()));

        reset_in_resp();
        run_frame("post_rst", vecs[1]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
